// File: rtl/pkt_dma_pkg.sv
// Shared definitions for the packet DMA writer and the host-facing register bank.
// dma_state_t is the 2-bit status the bank mirrors into control[1:0].
package pkt_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } dma_state_t;

   // Bit position of the status field inside the host control register.
   localparam int STATE_LSB = 0;

endpackage

// File: rtl/pkt_dma_writer_if.sv
// Bus bundle for the packet DMA writer: capture stream (s_*) plus the
// Avalon-MM write master (m_*).
//   master : DMA side  - consumes the stream, drives the Avalon request
//   slave  : far side  - sources the stream, answers with m_waitrequest
interface pkt_dma_writer_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 32
);
   logic [N-1:0]      s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;
   logic [ADDR_W-1:0] m_address;
   logic              m_write;
   logic [N-1:0]      m_writedata;
   logic [N/8-1:0]    m_byteenable;
   logic              m_waitrequest;

   modport master (
      input  s_data, s_valid, s_last, m_waitrequest,
      output s_ready, m_address, m_write, m_writedata, m_byteenable
   );

   modport slave (
      output s_data, s_valid, s_last, m_waitrequest,
      input  s_ready, m_address, m_write, m_writedata, m_byteenable
   );
endinterface

// File: rtl/pkt_dma_writer.sv
// Avalon-MM write master that copies one captured packet from the capture
// stream into SDRAM, one word per FETCH/WRITE pair.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   start                one-cycle pulse, begins a transfer from IDLE/DONE/ERROR
//   pkt_addr, pkt_len    destination byte address (N/8 aligned) and byte length
//   bus (master)         stream in (s_*) and Avalon write master (m_*)
//   state                IDLE / BUSY / DONE / ERROR status for the register bank
//   words_done           beats accepted by the slave in the current or last transfer
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing since reset; waits for start
// S_FETCH | s_ready high, waiting for the next stream word
// S_WRITE | m_write high with one captured word, waiting for accept
// S_DONE  | packet written completely (sticky)
// S_ERROR | misaligned address or s_last disagreeing with pkt_len (sticky)
module pkt_dma_writer
   import pkt_dma_pkg::*;
#(
   parameter int N      = 32,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] pkt_addr,
   input  logic [LEN_W-1:0]  pkt_len,
   pkt_dma_writer_if.master  bus,
   output logic [1:0]        state,
   output logic [LEN_W-1:0]  words_done
);

   localparam int BPB = N / 8;
   localparam int AL  = $clog2(BPB);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd4;

   // Byte enables of the final beat: the low (len mod BPB) lanes, or all lanes
   // when the length is a whole number of words.
   function automatic logic [BPB-1:0] be_fn(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] r;
      r = len % LEN_W'(BPB);
      for (int i = 0; i < BPB; i++) begin
         be_fn[i] = (r == '0) || (LEN_W'(i) < r);
      end
   endfunction

   logic [2:0]        fsm;
   logic [ADDR_W-1:0] addr_q;
   logic [N-1:0]      data_q;
   logic [BPB-1:0]    be_q;
   logic              last_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  words_left;

   logic              misaligned;
   logic [LEN_W-1:0]  words_ceil;

   assign misaligned = (pkt_addr % ADDR_W'(BPB)) != '0;
   // Rounded-up word count without forming len+BPB-1, which could overflow.
   assign words_ceil = (pkt_len >> AL) + LEN_W'((pkt_len % LEN_W'(BPB)) != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm        <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         be_q       <= '0;
         last_q     <= 1'b0;
         len_q      <= '0;
         words_left <= '0;
         words_done <= '0;
      end else begin
         case (fsm)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  addr_q     <= pkt_addr;
                  len_q      <= pkt_len;
                  words_left <= words_ceil;
                  words_done <= '0;
                  if (misaligned)           fsm <= S_ERROR;
                  else if (pkt_len == '0)   fsm <= S_DONE;
                  else                      fsm <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (bus.s_valid) begin
                  data_q <= bus.s_data;
                  last_q <= bus.s_last;
                  be_q   <= (words_left == LEN_W'(1)) ? be_fn(len_q) : '1;
                  fsm    <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!bus.m_waitrequest) begin
                  words_done <= words_done + LEN_W'(1);
                  words_left <= words_left - LEN_W'(1);
                  addr_q     <= addr_q + ADDR_W'(BPB);
                  if (words_left == LEN_W'(1))
                     fsm <= last_q ? S_DONE : S_ERROR;
                  else if (last_q)
                     fsm <= S_ERROR;
                  else
                     fsm <= S_FETCH;
               end
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready      = (fsm == S_FETCH);
   assign bus.m_write      = (fsm == S_WRITE);
   assign bus.m_address    = addr_q;
   assign bus.m_writedata  = data_q;
   assign bus.m_byteenable = be_q;

   always_comb begin
      state = IDLE;
      case (fsm)
         S_FETCH, S_WRITE: state = BUSY;
         S_DONE:           state = DONE;
         S_ERROR:          state = ERROR;
         default:          state = IDLE;
      endcase
   end

endmodule
